// File: rtl/mul_seq_48x48.sv
// 2*HW x 2*HW unsigned sequential multiplier built from one HW x HW
// combinational multiplier, accumulating up to four partial products.

module unsigned_mul #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] P
);
    assign P = A * B;
endmodule

module mul_seq_48x48 #(
    parameter int HW        = 24,
    parameter int SKIP_ZERO = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*HW-1:0]   IN1,
    input  logic [2*HW-1:0]   IN2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*HW-1:0]   OUT,
    output logic              busy,
    output logic [CNT_W-1:0]  op_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2*HW-1:0]    r_a;
    logic [2*HW-1:0]    r_b;
    logic [1:0]         r_step;
    logic [4*HW-1:0]    r_acc;
    logic [4*HW-1:0]    r_out;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic [3:0]         w_act_in;
    logic [3:0]         w_act_reg;
    logic [3:0]         w_higher;
    logic               w_last;
    logic [HW-1:0]      w_ma;
    logic [HW-1:0]      w_mb;
    logic [2*HW-1:0]    w_p;
    logic [4*HW-1:0]    w_ext;
    logic [4*HW-1:0]    w_sh;
    logic [4*HW-1:0]    w_acc_nxt;

    // Bit i set when step i contributes a non-zero partial product
    function automatic logic [3:0] f_active(
        input logic [2*HW-1:0] a,
        input logic [2*HW-1:0] b
    );
        logic al, ah, bl, bh;
        al = |a[HW-1:0];
        ah = |a[2*HW-1:HW];
        bl = |b[HW-1:0];
        bh = |b[2*HW-1:HW];
        if (SKIP_ZERO == 0) return 4'hF;
        return {ah & bh, ah & bl, al & bh, al & bl};
    endfunction

    function automatic logic [1:0] f_first(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) r = 2'(i);
        return r;
    endfunction

    assign w_accept  = in_valid & in_ready;
    assign w_act_in  = f_active(IN1, IN2);
    assign w_act_reg = f_active(r_a, r_b);
    assign w_higher  = w_act_reg & (4'b1110 << r_step);
    assign w_last    = (w_higher == 4'd0);

    always_comb begin
        w_ma = '0;
        w_mb = '0;
        unique case (r_step)
            2'd0: begin w_ma = r_a[HW-1:0];    w_mb = r_b[HW-1:0];    end
            2'd1: begin w_ma = r_a[HW-1:0];    w_mb = r_b[2*HW-1:HW]; end
            2'd2: begin w_ma = r_a[2*HW-1:HW]; w_mb = r_b[HW-1:0];    end
            2'd3: begin w_ma = r_a[2*HW-1:HW]; w_mb = r_b[2*HW-1:HW]; end
        endcase
    end

    unsigned_mul #(.WIDTH(HW)) u_mul (
        .A (w_ma),
        .B (w_mb),
        .P (w_p)
    );

    assign w_ext = {{(2*HW){1'b0}}, w_p};

    always_comb begin
        w_sh = w_ext;
        unique case (r_step)
            2'd0:       w_sh = w_ext;
            2'd1, 2'd2: w_sh = w_ext << HW;
            2'd3:       w_sh = w_ext << (2*HW);
        endcase
    end

    assign w_acc_nxt = r_acc + w_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:
                if (in_valid)
                    w_state_nxt = (w_act_in == 4'd0) ? S_DONE : S_MUL;
            S_MUL:
                if (w_last) w_state_nxt = S_DONE;
            S_DONE:
                if (out_ready) begin
                    if (in_valid)
                        w_state_nxt = (w_act_in == 4'd0) ? S_DONE : S_MUL;
                    else
                        w_state_nxt = S_IDLE;
                end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            S_IDLE: begin in_ready = 1'b1; busy = 1'b0; end
            S_MUL:  in_ready = 1'b0;
            S_DONE: begin in_ready = out_ready; out_valid = 1'b1; end
            default: begin in_ready = 1'b0; busy = 1'b0; end
        endcase
    end

    // OUT is only reloaded on DONE entry so it stays stable under back-pressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_step <= 2'd0;
            r_acc  <= '0;
            r_out  <= '0;
        end else if (w_accept) begin
            r_a    <= IN1;
            r_b    <= IN2;
            r_acc  <= '0;
            r_step <= f_first(w_act_in);
            if (w_act_in == 4'd0) r_out <= '0;
        end else if (r_state == S_MUL) begin
            r_acc  <= w_acc_nxt;
            r_step <= f_first(w_higher);
            if (w_last) r_out <= w_acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_cnt <= '0;
        else if (out_valid & out_ready) r_cnt <= r_cnt + 1'b1;
    end

    assign OUT    = r_out;
    assign op_cnt = r_cnt;

endmodule

// File: tb/tb_mul_seq_48x48.sv
// Bench for mul_seq_48x48: instance 0 skips zero steps, instance 1 never
// skips; both are checked against plain A*B and a step-count latency model.

module tb_mul_seq_48x48;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [47:0] in1       [2];
    logic [47:0] in2       [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [95:0] out_w     [2];
    logic        busy      [2];
    logic [15:0] op_cnt    [2];

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] exp_cnt [2];

    always #5 clk = ~clk;

    mul_seq_48x48 #(.HW(24), .SKIP_ZERO(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .IN1(in1[0]), .IN2(in2[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .OUT(out_w[0]), .busy(busy[0]), .op_cnt(op_cnt[0])
    );

    mul_seq_48x48 #(.HW(24), .SKIP_ZERO(0), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .IN1(in1[1]), .IN2(in2[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .OUT(out_w[1]), .busy(busy[1]), .op_cnt(op_cnt[1])
    );

    function automatic logic [95:0] model_prod(input logic [47:0] a, input logic [47:0] b);
        logic [95:0] x;
        logic [95:0] y;
        x = {48'd0, a};
        y = {48'd0, b};
        return x * y;
    endfunction

    // Latency = 1 + number of half-pairs that both are non-zero (or 4 if no skipping)
    function automatic int model_lat(input int d, input logic [47:0] a, input logic [47:0] b);
        int n;
        if (d == 1) return 5;
        n = 0;
        if (a[23:0]  != 0 && b[23:0]  != 0) n++;
        if (a[23:0]  != 0 && b[47:24] != 0) n++;
        if (a[47:24] != 0 && b[23:0]  != 0) n++;
        if (a[47:24] != 0 && b[47:24] != 0) n++;
        return n + 1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            in1[d]       = '0;
            in2[d]       = '0;
            exp_cnt[d]   = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic run_op(input int d, input logic [47:0] a, input logic [47:0] b,
                          input int lat_req, input string nm);
        int lat;
        logic [95:0] exp_p;
        exp_p = model_prod(a, b);
        @(negedge clk);
        in1[d] = a;
        in2[d] = b;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b0;
        #1;
        n_total++;
        if (in_ready[d] !== 1'b1)
            $display("FAIL %s in_ready: got %b want 1", nm, in_ready[d]);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        lat = 1;
        while (out_valid[d] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        n_total++;
        if (lat != lat_req)
            $display("FAIL %s latency: got %0d want %0d", nm, lat, lat_req);
        else n_pass++;
        n_total++;
        if (out_w[d] !== exp_p)
            $display("FAIL %s OUT: got %h want %h", nm, out_w[d], exp_p);
        else n_pass++;
        out_ready[d] = 1'b1;
        @(posedge clk);
        exp_cnt[d] = exp_cnt[d] + 16'd1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        n_total++;
        if (op_cnt[d] !== exp_cnt[d])
            $display("FAIL %s op_cnt: got %0d want %0d", nm, op_cnt[d], exp_cnt[d]);
        else n_pass++;
        n_total++;
        if (busy[d] !== 1'b0)
            $display("FAIL %s busy_after: got %b want 0", nm, busy[d]);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (out_w[d] !== 96'd0 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
                in_ready[d] !== 1'b1 || op_cnt[d] !== 16'd0)
                $display("FAIL reset%0d: got out=%h ov=%b busy=%b ir=%b cnt=%0d want 0/0/0/1/0",
                         d, out_w[d], out_valid[d], busy[d], in_ready[d], op_cnt[d]);
            else n_pass++;
        end
    endtask

    task automatic test_full_scale();
        run_op(0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 5, "full_skip");
        n_total++;
        if (out_w[0] !== 96'hFFFF_FFFF_FFFE_0000_0000_0001)
            $display("FAIL full_const: got %h want %h", out_w[0],
                     96'hFFFF_FFFF_FFFE_0000_0000_0001);
        else n_pass++;
        run_op(1, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 5, "full_noskip");
    endtask

    task automatic test_zero();
        run_op(0, 48'h0, 48'h1234_5678_9ABC, 1, "zero_skip");
        run_op(1, 48'h0, 48'h1234_5678_9ABC, 5, "zero_noskip");
    endtask

    task automatic test_sparse();
        run_op(0, 48'h3, 48'h5, 2, "sparse_low");
        run_op(0, 48'h000001_000000, 48'h000001_000000, 2, "sparse_high");
        n_total++;
        if (out_w[0] !== (96'd1 << 48))
            $display("FAIL sparse_high_const: got %h want %h", out_w[0], 96'd1 << 48);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int w;
        @(negedge clk);
        in1[0] = 48'd7;
        in2[0] = 48'd9;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        w = 0;
        while (out_valid[0] !== 1'b1 && w < 20) begin
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (out_w[0] !== 96'd63 || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0)
                $display("FAIL hold%0d: got out=%0d ov=%b ir=%b want 63/1/0",
                         i, out_w[0], out_valid[0], in_ready[0]);
            else n_pass++;
            @(posedge clk);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in1[0] = 48'd2;
        in2[0] = 48'd2;
        #1;
        n_total++;
        if (in_ready[0] !== 1'b1 || out_w[0] !== 96'd63)
            $display("FAIL handoff: got ir=%b out=%0d want 1/63", in_ready[0], out_w[0]);
        else n_pass++;
        @(posedge clk);
        exp_cnt[0] = exp_cnt[0] + 16'd1;
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        n_total++;
        if (out_valid[0] !== 1'b0 || op_cnt[0] !== exp_cnt[0])
            $display("FAIL handoff_next: got ov=%b cnt=%0d want 0/%0d",
                     out_valid[0], op_cnt[0], exp_cnt[0]);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (out_valid[0] !== 1'b1 || out_w[0] !== 96'd4)
            $display("FAIL handoff_result: got ov=%b out=%0d want 1/4", out_valid[0], out_w[0]);
        else n_pass++;
        out_ready[0] = 1'b1;
        @(posedge clk);
        exp_cnt[0] = exp_cnt[0] + 16'd1;
        @(negedge clk);
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        in1[0] = 48'hFFFF_FFFF_FFFF;
        in2[0] = 48'hFFFF_FFFF_FFFF;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid[0] !== 1'b0 || out_w[0] !== 96'd0 || busy[0] !== 1'b0)
            $display("FAIL reset_mid: got ov=%b out=%h busy=%b want 0/0/0",
                     out_valid[0], out_w[0], busy[0]);
        else n_pass++;
        exp_cnt[0] = '0;
        exp_cnt[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++;
        if (in_ready[0] !== 1'b1)
            $display("FAIL reset_mid_ready: got %b want 1", in_ready[0]);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b0 || out_w[0] !== 96'd0) seen++;
        end
        n_total++;
        if (seen != 0)
            $display("FAIL reset_mid_stale: got %0d stale cycles want 0", seen);
        else n_pass++;
        out_ready[0] = 1'b0;
    endtask

    task automatic test_random(input int d, input int nops);
        logic [95:0] q[$];
        logic [47:0] a, b;
        logic [95:0] exp_p;
        logic        have;
        int          acc_n, hs, cyc;
        logic [47:0] h[4];
        have  = 1'b0;
        acc_n = 0;
        hs    = 0;
        cyc   = 0;
        while ((acc_n < nops || q.size() != 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (!have && acc_n < nops) begin
                for (int k = 0; k < 4; k++)
                    h[k] = ($urandom_range(0, 3) == 0) ? 48'd0 : {24'd0, 24'($urandom)};
                a = {h[1][23:0], h[0][23:0]};
                b = {h[3][23:0], h[2][23:0]};
                have = 1'b1;
                in1[d] = a;
                in2[d] = b;
            end
            if (have && !in_valid[d]) in_valid[d] = ($urandom_range(0, 1) == 1);
            out_ready[d] = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid[d] && out_ready[d]) begin
                exp_p = (q.size() != 0) ? q.pop_front() : 96'hX;
                hs++;
                n_total++;
                if (out_w[d] !== exp_p)
                    $display("FAIL rand%0d_out: got %h want %h", d, out_w[d], exp_p);
                else n_pass++;
            end
            if (in_valid[d] && in_ready[d]) begin
                q.push_back(model_prod(in1[d], in2[d]));
                acc_n++;
                have = 1'b0;
            end
            @(posedge clk);
            #1;
            if (!have) in_valid[d] = 1'b0;
        end
        n_total++;
        if (cyc >= 40000)
            $display("FAIL rand%0d_timeout: got %0d accepted want %0d", d, acc_n, nops);
        else n_pass++;
        @(negedge clk);
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        exp_cnt[d] = exp_cnt[d] + 16'(hs);
        n_total++;
        if (op_cnt[d] !== exp_cnt[d])
            $display("FAIL rand%0d_opcnt: got %0d want %0d", d, op_cnt[d], exp_cnt[d]);
        else n_pass++;
    endtask

    task automatic test_rand_latency(input int d, input int nops);
        logic [47:0] a, b;
        for (int i = 0; i < nops; i++) begin
            a = {24'($urandom_range(0, 1) * $urandom), 24'($urandom_range(0, 1) * $urandom)};
            b = {24'($urandom_range(0, 1) * $urandom), 24'($urandom_range(0, 1) * $urandom)};
            run_op(d, a, b, model_lat(d, a, b), "rand_lat");
        end
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_zero();
        test_sparse();
        test_back_to_back();
        test_reset_mid();
        test_rand_latency(0, 20);
        test_rand_latency(1, 10);
        test_random(0, 1000);
        test_random(1, 1000);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
